// File: rtl/alu_pkt_initiator.sv
// alu_pkt_initiator
//   Turns an ALU command plus its 32-bit operands into a byte packet for a UART
//   transmitter, then collects the response bytes and returns them as 32-bit words.
//
//   Packet: opcode, 0x00, len[7:0], len[15:8], then every operand LSB first,
//   where len = 4 + 4*count.
//   Response: count words for ECHO, one word for every other opcode, each
//   assembled LSB first from the receive stream.
//
//   Opcodes: ECHO=0x01, ADD=0x02, MUL=0x03, DIV=0x04. Any other opcode, or a
//   count of 0, is rejected.
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   cmd_valid_i/cmd_ready_o             command handshake
//   cmd_opcode_i, cmd_count_i           opcode and operand count (1..15)
//   op_valid_i/op_ready_o/op_data_i     operand word stream
//   tx_valid_o/tx_ready_i/tx_data_o     bytes toward the UART transmitter
//   rx_valid_i/rx_ready_o/rx_data_i     bytes from the UART receiver
//   rsp_valid_o/rsp_ready_i/rsp_data_o  result words
//   busy_o                              high whenever not idle
//   err_o                               one-cycle pulse: rejected command or timeout
module alu_pkt_initiator #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_opcode_i,
  input  logic [3:0]            cmd_count_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [31:0]           op_data_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [7:0]  OPCODE_ECHO = 8'h01;
  localparam logic [7:0]  OPCODE_ADD  = 8'h02;
  localparam logic [7:0]  OPCODE_MUL  = 8'h03;
  localparam logic [7:0]  OPCODE_DIV  = 8'h04;
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StResponse,
    StDeliver
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [1:0]            hdr_idx_q, hdr_idx_d;     // header byte currently presented
  logic [1:0]            byte_idx_q, byte_idx_d;   // next operand byte to load
  logic [3:0]            fetched_q, fetched_d;     // operand words accepted
  logic [3:0]            sent_q, sent_d;           // operand words fully loaded into tx
  logic [31:0]           op_q, op_d;
  logic                  op_full_q, op_full_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [1:0]            rx_idx_q, rx_idx_d;
  logic [31:0]           word_q, word_d;
  logic [3:0]            words_left_q, words_left_d;
  logic [31:0]           idle_q, idle_d;
  logic                  err_q, err_d;

  logic        cmd_legal;
  logic        op_acc, rx_acc, tx_free;
  logic        src_valid;
  logic [31:0] src_word;
  logic [15:0] pkt_len;

  assign cmd_ready_o = (state_q == StIdle);
  assign rx_ready_o  = (state_q == StIdle) || (state_q == StResponse);
  assign op_ready_o  = ((state_q == StHeader) || (state_q == StPayload)) && !op_full_q &&
                       (fetched_q != count_q);
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign rsp_valid_o = (state_q == StDeliver);
  assign rsp_data_o  = word_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

  assign cmd_legal = (cmd_count_i != 4'd0) &&
                     ((cmd_opcode_i == OPCODE_ECHO) || (cmd_opcode_i == OPCODE_ADD) ||
                      (cmd_opcode_i == OPCODE_MUL)  || (cmd_opcode_i == OPCODE_DIV));

  assign op_acc  = op_valid_i && op_ready_o;
  assign rx_acc  = rx_valid_i && rx_ready_o;
  assign tx_free = !tx_valid_q || tx_ready_i;
  assign pkt_len = 16'd4 + {10'd0, count_q, 2'b00};

  // A word accepted this cycle can feed the transmitter directly, which keeps
  // the byte stream gap-free across operand boundaries.
  assign src_valid = op_full_q || op_acc;
  assign src_word  = op_full_q ? op_q : op_data_i;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    hdr_idx_d    = hdr_idx_q;
    byte_idx_d   = byte_idx_q;
    fetched_d    = fetched_q;
    sent_d       = sent_q;
    op_d         = op_q;
    op_full_d    = op_full_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    rx_idx_d     = rx_idx_q;
    word_d       = word_q;
    words_left_d = words_left_q;
    idle_d       = idle_q;
    err_d        = 1'b0;

    if (op_acc) begin
      op_d      = op_data_i;
      op_full_d = 1'b1;
      fetched_d = fetched_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_legal) begin
            state_d      = StHeader;
            count_d      = cmd_count_i;
            hdr_idx_d    = 2'd0;
            byte_idx_d   = 2'd0;
            fetched_d    = 4'd0;
            sent_d       = 4'd0;
            op_full_d    = 1'b0;
            tx_valid_d   = 1'b1;
            tx_data_d    = DATA_WIDTH'(cmd_opcode_i);
            rx_idx_d     = 2'd0;
            words_left_d = (cmd_opcode_i == OPCODE_ECHO) ? cmd_count_i : 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StHeader, StPayload: begin
        if (tx_free) begin
          if ((state_q == StHeader) && (hdr_idx_q != 2'd3)) begin
            hdr_idx_d  = hdr_idx_q + 2'd1;
            tx_valid_d = 1'b1;
            case (hdr_idx_q)
              2'd0:    tx_data_d = '0;
              2'd1:    tx_data_d = DATA_WIDTH'(pkt_len[7:0]);
              default: tx_data_d = DATA_WIDTH'(pkt_len[15:8]);
            endcase
          end else begin
            state_d = StPayload;
            if (src_valid) begin
              tx_valid_d = 1'b1;
              tx_data_d  = DATA_WIDTH'(src_word[{byte_idx_q, 3'b000} +: 8]);
              byte_idx_d = byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                op_full_d = 1'b0;
                sent_d    = sent_q + 4'd1;
              end
            end else begin
              tx_valid_d = 1'b0;
              // Last payload byte has just gone out.
              if (sent_q == count_q) begin
                state_d  = StResponse;
                idle_d   = '0;
                rx_idx_d = 2'd0;
              end
            end
          end
        end
      end

      StResponse: begin
        if (rx_acc) begin
          word_d[{rx_idx_q, 3'b000} +: 8] = rx_data_i[7:0];
          rx_idx_d = rx_idx_q + 2'd1;
          idle_d   = '0;
          if (rx_idx_q == 2'd3) begin
            state_d = StDeliver;
          end
        end else if (idle_q >= TimeoutLast) begin
          err_d    = 1'b1;
          state_d  = StIdle;
          rx_idx_d = 2'd0;
          word_d   = '0;
          idle_d   = '0;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      StDeliver: begin
        if (rsp_ready_i) begin
          words_left_d = words_left_q - 4'd1;
          if (words_left_q == 4'd1) begin
            state_d = StIdle;
          end else begin
            state_d = StResponse;
            idle_d  = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      count_q      <= '0;
      hdr_idx_q    <= '0;
      byte_idx_q   <= '0;
      fetched_q    <= '0;
      sent_q       <= '0;
      op_q         <= '0;
      op_full_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      rx_idx_q     <= '0;
      word_q       <= '0;
      words_left_q <= '0;
      idle_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hdr_idx_q    <= hdr_idx_d;
      byte_idx_q   <= byte_idx_d;
      fetched_q    <= fetched_d;
      sent_q       <= sent_d;
      op_q         <= op_d;
      op_full_q    <= op_full_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      rx_idx_q     <= rx_idx_d;
      word_q       <= word_d;
      words_left_q <= words_left_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_pkt_initiator.sv
// Scoreboard bench for alu_pkt_initiator: stimulus pushes expected tx bytes and
// response words into queues; a negedge monitor pops and compares on each transfer.
module tb_alu_pkt_initiator;

  localparam logic [7:0] OpEcho = 8'h01;
  localparam logic [7:0] OpAdd  = 8'h02;
  localparam logic [7:0] OpMul  = 8'h03;
  localparam logic [7:0] OpDiv  = 8'h04;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i = '0;
  logic [3:0]  cmd_count_i = '0;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [31:0] op_data_i;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  tx_data_o;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  rx_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic        busy_o;
  logic        err_o;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int tx_xfers = 0;
  int last_rx_edge = 0;
  bit tx_toggle = 1'b0;
  bit rsp_seen = 1'b0;

  logic [7:0]  tx_exp[$];
  logic [31:0] rsp_exp[$];
  logic [31:0] op_src[$];
  logic [7:0]  rx_src[$];

  alu_pkt_initiator #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_opcode_i (cmd_opcode_i),
    .cmd_count_i  (cmd_count_i),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .op_data_i    (op_data_i),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .rx_data_i    (rx_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  bit          tx_stall_q = 1'b0;
  logic [7:0]  tx_prev_q;
  bit          rsp_stall_q = 1'b0;
  logic [31:0] rsp_prev_q;
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_stall_q  = 1'b0;
      rsp_stall_q = 1'b0;
    end else begin
      if (tx_stall_q) chk("tx_hold", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, tx_prev_q});
      if (rsp_stall_q) chk("rsp_hold", rsp_valid_o ? rsp_data_o : 32'hxxxx_xxxx, rsp_prev_q);
      if (tx_valid_o && tx_ready_i) begin
        tx_xfers++;
        if (tx_exp.size() == 0) chk("tx_unexpected", {24'd0, tx_data_o}, 32'hffff_ffff);
        else chk("tx_byte", {24'd0, tx_data_o}, {24'd0, tx_exp.pop_front()});
      end
      if (rsp_valid_o) rsp_seen = 1'b1;
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_exp.size() == 0) chk("rsp_unexpected", rsp_data_o, 32'hxxxx_xxxx);
        else chk("rsp_word", rsp_data_o, rsp_exp.pop_front());
      end
      tx_stall_q  = tx_valid_o && !tx_ready_i;
      tx_prev_q   = tx_data_o;
      rsp_stall_q = rsp_valid_o && !rsp_ready_i;
      rsp_prev_q  = rsp_data_o;
    end
  end

  // Operand source
  initial begin : op_drv
    bit hs;
    op_valid_i = 1'b0;
    op_data_i  = '0;
    forever begin
      @(negedge clk);
      hs = op_valid_i && op_ready_o && rst_n;
      @(posedge clk);
      #1;
      if (hs) op_valid_i = 1'b0;
      if (!op_valid_i && op_src.size() > 0) begin
        op_valid_i = 1'b1;
        op_data_i  = op_src.pop_front();
      end
    end
  end

  // Receive-byte source; remembers the edge number of the latest rx transfer
  initial begin : rx_drv
    bit hs;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    forever begin
      @(negedge clk);
      hs = rx_valid_i && rx_ready_o && rst_n;
      if (hs) last_rx_edge = cyc + 1;
      @(posedge clk);
      #1;
      if (hs) rx_valid_i = 1'b0;
      if (!rx_valid_i && rx_src.size() > 0) begin
        rx_valid_i = 1'b1;
        rx_data_i  = rx_src.pop_front();
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (tx_toggle) tx_ready_i = !tx_ready_i;
  end

  // Queue the full expected packet for a legal command and feed its operands.
  task automatic expect_pkt(input logic [7:0] opc, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input int cnt);
    logic [31:0] ws[3];
    logic [15:0] len;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    len = 16'(4 + 4 * cnt);
    tx_exp.push_back(opc);
    tx_exp.push_back(8'h00);
    tx_exp.push_back(len[7:0]);
    tx_exp.push_back(len[15:8]);
    for (int i = 0; i < cnt; i++) begin
      op_src.push_back(ws[i]);
      for (int b = 0; b < 4; b++) tx_exp.push_back(8'(ws[i] >> (8 * b)));
    end
  endtask

  task automatic send_cmd(input logic [7:0] opc, input logic [3:0] cnt);
    @(posedge clk);
    #1;
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = opc;
    cmd_count_i  = cnt;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic push_rx_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) rx_src.push_back(8'(w >> (8 * b)));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy_o || tx_exp.size() != 0 || rsp_exp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {25'd0, cmd_ready_o, rx_ready_o, tx_valid_o, op_ready_o, rsp_valid_o, busy_o, err_o},
        32'b110_0000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk_idle_outputs("reset_outputs");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset_outputs");

    // ADD 5 + 7: 12 back-to-back bytes, one result word
    begin
      int base, n;
      expect_pkt(OpAdd, 32'h5, 32'h7, 32'h0, 2);
      rsp_exp.push_back(32'h0000_000C);
      send_cmd(OpAdd, 4'd2);
      push_rx_word(32'h0000_000C);
      base = tx_xfers;
      n = 0;
      while (tx_xfers - base < 12 && n < 40) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk("add_tx_cycles", 32'(n), 32'd12);
      wait_done("add_done", 100);
      chk_idle_outputs("add_idle");
    end

    // ECHO with the first result word stalled for 5 cycles
    begin
      int n = 0;
      expect_pkt(OpEcho, 32'h4433_2211, 32'h8877_6655, 32'h0, 2);
      rsp_exp.push_back(32'h4433_2211);
      rsp_exp.push_back(32'h8877_6655);
      rsp_ready_i = 1'b0;
      send_cmd(OpEcho, 4'd2);
      push_rx_word(32'h4433_2211);
      push_rx_word(32'h8877_6655);
      while (!rsp_valid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("echo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("echo_stall_data", rsp_valid_o ? rsp_data_o : 32'hxxxx_xxxx, 32'h4433_2211);
      end
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b1;
      wait_done("echo_done", 100);
    end

    // DIV, 3 operands, tx_ready toggling every cycle
    begin
      expect_pkt(OpDiv, 32'hDEAD_BEEF, 32'h0123_4567, 32'hA5A5_5A5A, 3);
      rsp_exp.push_back(32'h7654_3210);
      tx_ready_i = 1'b0;
      tx_toggle  = 1'b1;
      send_cmd(OpDiv, 4'd3);
      push_rx_word(32'h7654_3210);
      wait_done("bp_done", 200);
      @(negedge clk);
      tx_toggle  = 1'b0;
      tx_ready_i = 1'b1;
    end

    // Rejected commands: unknown opcode 0x00, count 0, unknown opcode 0x7F
    begin
      logic [11:0] bad[3];
      bad[0] = {8'h00, 4'd2};
      bad[1] = {OpEcho, 4'd0};
      bad[2] = {8'h7F, 4'd1};
      for (int i = 0; i < 3; i++) begin
        send_cmd(bad[i][11:4], bad[i][3:0]);
        @(negedge clk);
        chk("bad_err_pulse", {29'd0, err_o, tx_valid_o, cmd_ready_o}, 32'b101);
        @(negedge clk);
        chk("bad_err_clear", {29'd0, err_o, tx_valid_o, busy_o}, 32'b000);
      end
    end

    // MUL with only 2 response bytes: timeout 50 cycles after the 2nd byte
    begin
      int n = 0;
      expect_pkt(OpMul, 32'h0000_0003, 32'h0000_0004, 32'h0, 2);
      rsp_seen = 1'b0;
      send_cmd(OpMul, 4'd2);
      rx_src.push_back(8'h0C);
      rx_src.push_back(8'h00);
      while (!err_o && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_err", {31'd0, err_o}, 32'd1);
      chk("timeout_delay", 32'(cyc - last_rx_edge), 32'd50);
      @(negedge clk);
      chk_idle_outputs("timeout_idle");
      chk("timeout_no_rsp", {31'd0, rsp_seen}, 32'd0);
      // A fresh transaction must not inherit the dropped partial word.
      expect_pkt(OpAdd, 32'h1, 32'h1, 32'h0, 2);
      rsp_exp.push_back(32'h1234_5678);
      send_cmd(OpAdd, 4'd2);
      push_rx_word(32'h1234_5678);
      wait_done("post_timeout_done", 100);
    end

    // Reset right after the 6th tx byte, then a clean ADD
    begin
      int base, n;
      expect_pkt(OpAdd, 32'hCAFE_F00D, 32'h1111_2222, 32'h0, 2);
      send_cmd(OpAdd, 4'd2);
      base = tx_xfers;
      n = 0;
      while (tx_xfers - base < 6 && n < 40) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk("rst_six_bytes", 32'(tx_xfers - base), 32'd6);
      rst_n = 1'b0;
      op_valid_i = 1'b0;
      rx_valid_i = 1'b0;
      op_src.delete();
      rx_src.delete();
      tx_exp.delete();
      #1;
      chk_idle_outputs("rst_async_outputs");
      repeat (2) @(negedge clk);
      chk_idle_outputs("rst_held_outputs");
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("rst_release_outputs");
      chk("rst_no_tx", 32'(tx_xfers - base), 32'd6);
      expect_pkt(OpAdd, 32'h0000_0001, 32'h0000_0002, 32'h0, 2);
      rsp_exp.push_back(32'h0000_0003);
      send_cmd(OpAdd, 4'd2);
      push_rx_word(32'h0000_0003);
      wait_done("post_rst_done", 100);
    end

    @(negedge clk);
    chk("final_queues_empty", 32'(tx_exp.size() + rsp_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pkt_initiator.md
ALU_PKT_INITIATOR -- requirements
Module: alu_pkt_initiator

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, UART byte width; TIMEOUT_CYCLES, default 100000, maximum idle cycles between response bytes.
REQ-002 Port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
REQ-005 Port cmd_opcode_i  input  8  opcode (config_pkg OPCODE_ECHO/ADD/MUL/DIV).
REQ-006 Port cmd_count_i  input  4  number of 32-bit operands, legal range 1..15.
REQ-007 Port op_valid_i / op_ready_o / op_data_i  in/out/in  1/1/32  operand stream.
REQ-008 Port tx_valid_o / tx_ready_i / tx_data_o  out/in/out  1/1/8  bytes toward the UART transmitter.
REQ-009 Port rx_valid_i / rx_ready_o / rx_data_i  in/out/in  1/1/8  bytes from the UART receiver.
REQ-010 Port rsp_valid_o / rsp_ready_i / rsp_data_o  out/in/out  1/1/32  result words.
REQ-011 Port busy_o  output  1  high in any state other than IDLE.
REQ-012 Port err_o  output  1  one-cycle pulse on rejected command or response timeout.

Function
REQ-013 All handshakes SHALL be valid/ready; a transfer occurs on a cycle with both high; a valid, once raised, SHALL NOT drop and its data SHALL NOT change until the transfer.
REQ-014 The FSM SHALL have states IDLE, HEADER, PAYLOAD, RESPONSE and DELIVER.
REQ-015 IDLE: cmd_ready_o=1; rx_ready_o=1, with received bytes discarded; all other outputs 0.
REQ-016 On a command accept with an unknown opcode or cmd_count_i=0, the block SHALL pulse err_o the next cycle, transmit nothing and remain in IDLE.
REQ-017 On a legal accept, the block SHALL latch opcode and count, go to HEADER, and assert tx_valid_o on the next cycle.
REQ-018 HEADER SHALL send 4 bytes: opcode, 0x00, len[7:0], len[15:0]>>8, where len = 4 + 4*count.
REQ-019 PAYLOAD, per operand:
- op_ready_o=1 only while no operand word is held;
- on accept, send the operand as 4 bytes, least-significant byte first;
- then fetch the next word.
REQ-020 After the last byte of the count-th operand transfers, the block SHALL enter RESPONSE.
REQ-021 Expected response word count SHALL be: count for OPCODE_ECHO, 1 otherwise.
REQ-022 RESPONSE: rx_ready_o=1; bytes assemble LSB-first into a 32-bit word; each completed word moves to DELIVER.
REQ-023 DELIVER: rsp_valid_o=1, rx_ready_o=0, until rsp_ready_i.
REQ-024 After a DELIVER transfer, the block SHALL return to RESPONSE if words remain, otherwise go to IDLE.
REQ-025 Response timeout:
- a 32-bit idle counter resets on entering RESPONSE and on each rx transfer, and increments otherwise in RESPONSE;
- on reaching TIMEOUT_CYCLES: pulse err_o, drop the partial word, go to IDLE.
REQ-026 tx_data_o SHALL be registered; a transfer and the next byte presentation SHALL sustain one byte per cycle while tx_ready_i=1.
REQ-027 rx_valid_i SHALL be ignored in HEADER and PAYLOAD (rx_ready_o=0).
REQ-028 cmd_ready_o SHALL be 0 outside IDLE.

Reset
REQ-029 Asserting rst_ni low SHALL immediately, without a clock, force IDLE and clear all counters, the held operand and the partial word.
REQ-030 During and after reset: cmd_ready_o=1, rx_ready_o=1, and tx_valid_o, op_ready_o, rsp_valid_o, busy_o, err_o all 0.
REQ-031 Reset mid-packet SHALL abort without emitting further bytes; the first post-reset command SHALL start a fresh header.
REQ-032 Deassertion SHALL take effect on the first rising clock edge after rst_ni goes high.

Verification
REQ-033 ADD, count=2, ops 0x00000005 and 0x00000007, tx_ready_i=1:
- tx = AD-op,00,0C,00,05,00,00,00,07,00,00,00 on 12 consecutive cycles;
- rx 0C,00,00,00 -> rsp_data_o=0x0000000C, then IDLE.
REQ-034 ECHO, count=2, ops 0x44332211 and 0x88776655:
- header len 0x000C;
- rx echoes the 8 payload bytes -> rsp words 0x44332211 then 0x88776655, with rsp_ready_i held low for 5 cycles on the first word without loss.
REQ-035 Backpressure: tx_ready_i toggling every cycle -> byte order unchanged and tx_data_o stable while stalled.
REQ-036 Opcode 0x00 or count=0 -> err_o pulse, no tx_valid_o, cmd_ready_o stays 1.
REQ-037 MUL, count=2, only 2 response bytes, TIMEOUT_CYCLES=50 -> err_o pulses 50 cycles after the 2nd byte, then IDLE with rsp_valid_o never asserted.
REQ-038 rst_ni low after the 6th tx byte -> outputs per REQ-030 within the same cycle; a following ADD sends a full correct header.
